id_ex_issue: RTL

- Decode/issue stage of the pipelined CPU.
- Takes fetched instructions from IF, decodes the opcode into an EXE_CMD for the ALU, and reads operands from the register file.
- Selects the immediate or the register value as the second operand, detects load-use hazards, and holds the result in the ID/EX pipeline register with valid/ready handshakes on both sides.
- It is the producer end of the ALU's A/B/ALUOp interface.

---
 rtl/id_ex_issue_pkg.sv | 84 ++++++++
 rtl/id_ex_issue_decoder.sv | 63 ++++++
 rtl/id_ex_issue.sv | 113 +++++++++++
 3 files changed

// File: rtl/id_ex_issue_pkg.sv
// Shared definitions for the decode/issue stage.
// Holds the datapath widths, opcode values, ALU command codes, branch-type
// codes and the decoded-control record that the decoder hands to the issue
// stage.
package id_ex_issue_pkg;

  localparam int WORD_LEN     = 32;
  localparam int EXE_CMD_LEN  = 4;
  localparam int REG_ADDR_LEN = 5;
  localparam int OPCODE_LEN   = 6;

  // Opcodes
  localparam logic [OPCODE_LEN-1:0] OP_NOP  = 6'd0;
  localparam logic [OPCODE_LEN-1:0] OP_ADD  = 6'd1;
  localparam logic [OPCODE_LEN-1:0] OP_SUB  = 6'd3;
  localparam logic [OPCODE_LEN-1:0] OP_AND  = 6'd5;
  localparam logic [OPCODE_LEN-1:0] OP_OR   = 6'd6;
  localparam logic [OPCODE_LEN-1:0] OP_NOR  = 6'd7;
  localparam logic [OPCODE_LEN-1:0] OP_XOR  = 6'd8;
  localparam logic [OPCODE_LEN-1:0] OP_SLA  = 6'd9;
  localparam logic [OPCODE_LEN-1:0] OP_SLL  = 6'd10;
  localparam logic [OPCODE_LEN-1:0] OP_SRA  = 6'd11;
  localparam logic [OPCODE_LEN-1:0] OP_SRL  = 6'd12;
  localparam logic [OPCODE_LEN-1:0] OP_ADDI = 6'd32;
  localparam logic [OPCODE_LEN-1:0] OP_SUBI = 6'd33;
  localparam logic [OPCODE_LEN-1:0] OP_LD   = 6'd36;
  localparam logic [OPCODE_LEN-1:0] OP_ST   = 6'd37;
  localparam logic [OPCODE_LEN-1:0] OP_BEZ  = 6'd40;
  localparam logic [OPCODE_LEN-1:0] OP_BNE  = 6'd41;
  localparam logic [OPCODE_LEN-1:0] OP_JMP  = 6'd42;

  // ALU commands
  localparam logic [EXE_CMD_LEN-1:0] EXE_NO_OPERATION = 4'd0;
  localparam logic [EXE_CMD_LEN-1:0] EXE_ADD          = 4'd1;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SUB          = 4'd2;
  localparam logic [EXE_CMD_LEN-1:0] EXE_AND          = 4'd3;
  localparam logic [EXE_CMD_LEN-1:0] EXE_OR           = 4'd4;
  localparam logic [EXE_CMD_LEN-1:0] EXE_NOR          = 4'd5;
  localparam logic [EXE_CMD_LEN-1:0] EXE_XOR          = 4'd6;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SLA          = 4'd7;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SLL          = 4'd8;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SRA          = 4'd9;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SRL          = 4'd10;

  // Branch types
  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEZ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_JMP  = 2'd3;

  typedef struct packed {
    logic [EXE_CMD_LEN-1:0] exe_cmd;
    logic                   imm_sel;     // operand B is the immediate
    logic                   wb_en;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [1:0]             br_type;
    logic                   use_src1;    // rf_addr1 register is read
    logic                   use_src2;    // rf_addr2 register is read
    logic                   addr2_dest;  // rf_addr2 comes from the dest field
    logic                   illegal;
  } dec_t;

  // ALU command for the register-register group.
  function automatic logic [EXE_CMD_LEN-1:0] rr_cmd(input logic [OPCODE_LEN-1:0] op);
    logic [EXE_CMD_LEN-1:0] cmd;
    cmd = EXE_NO_OPERATION;
    case (op)
      OP_ADD:  cmd = EXE_ADD;
      OP_SUB:  cmd = EXE_SUB;
      OP_AND:  cmd = EXE_AND;
      OP_OR:   cmd = EXE_OR;
      OP_NOR:  cmd = EXE_NOR;
      OP_XOR:  cmd = EXE_XOR;
      OP_SLA:  cmd = EXE_SLA;
      OP_SLL:  cmd = EXE_SLL;
      OP_SRA:  cmd = EXE_SRA;
      OP_SRL:  cmd = EXE_SRL;
      default: cmd = EXE_NO_OPERATION;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/id_ex_issue_decoder.sv
// Purely combinational opcode decoder for the issue stage.
// Ports:
//   opcode  in   instruction bits [31:26]
//   dec     out  decoded control record (ALU command, operand/memory/branch
//                controls, register-use flags, illegal flag)
// Undefined opcodes decode as a NOP with the illegal flag raised.
module id_ex_issue_decoder
  import id_ex_issue_pkg::*;
(
  input  logic [OPCODE_LEN-1:0] opcode,
  output dec_t                  dec
);

  always_comb begin
    dec         = '0;
    dec.exe_cmd = EXE_NO_OPERATION;
    dec.br_type = BR_NONE;
    case (opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
      OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
        dec.exe_cmd  = rr_cmd(opcode);
        dec.wb_en    = 1'b1;
        dec.use_src1 = 1'b1;
        dec.use_src2 = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        dec.exe_cmd  = (opcode == OP_ADDI) ? EXE_ADD : EXE_SUB;
        dec.imm_sel  = 1'b1;
        dec.wb_en    = 1'b1;
        dec.use_src1 = 1'b1;
      end
      OP_LD: begin
        dec.exe_cmd  = EXE_ADD;
        dec.imm_sel  = 1'b1;
        dec.wb_en    = 1'b1;
        dec.mem_rd   = 1'b1;
        dec.use_src1 = 1'b1;
      end
      OP_ST: begin
        dec.exe_cmd    = EXE_ADD;
        dec.imm_sel    = 1'b1;
        dec.mem_wr     = 1'b1;
        dec.use_src1   = 1'b1;
        dec.use_src2   = 1'b1;
        dec.addr2_dest = 1'b1;
      end
      OP_BEZ, OP_BNE: begin
        dec.imm_sel    = 1'b1;
        dec.br_type    = (opcode == OP_BEZ) ? BR_BEZ : BR_BNE;
        dec.use_src1   = 1'b1;
        dec.use_src2   = 1'b1;
        dec.addr2_dest = 1'b1;
      end
      OP_JMP: begin
        dec.imm_sel = 1'b1;
        dec.br_type = BR_JMP;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_issue.sv
// Decode/issue stage: decodes the instruction from IF, reads operands from
// the register file, checks for load-use hazards and holds the result in the
// ID/EX pipeline register with valid/ready handshakes on both sides.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready/in_instr/in_pc  instruction from IF
//   flush                             kill ID/EX contents and incoming instr
//   rf_addr1/2, rf_data1/2            register file read (same cycle)
//   out_valid/out_ready               ID/EX handshake toward EX
//   out_exe_cmd .. out_pc             ID/EX payload
//   out_illegal                       sticky undefined-opcode flag
module id_ex_issue
  import id_ex_issue_pkg::*;
#(
  parameter int WORD_LEN     = id_ex_issue_pkg::WORD_LEN,
  parameter int EXE_CMD_LEN  = id_ex_issue_pkg::EXE_CMD_LEN,
  parameter int REG_ADDR_LEN = id_ex_issue_pkg::REG_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_LEN-1:0]     in_instr,
  input  logic [WORD_LEN-1:0]     in_pc,
  input  logic                    flush,
  output logic [REG_ADDR_LEN-1:0] rf_addr1,
  output logic [REG_ADDR_LEN-1:0] rf_addr2,
  input  logic [WORD_LEN-1:0]     rf_data1,
  input  logic [WORD_LEN-1:0]     rf_data2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXE_CMD_LEN-1:0]  out_exe_cmd,
  output logic [WORD_LEN-1:0]     out_val1,
  output logic [WORD_LEN-1:0]     out_val2,
  output logic [WORD_LEN-1:0]     out_st_val,
  output logic [REG_ADDR_LEN-1:0] out_dest,
  output logic                    out_wb_en,
  output logic                    out_mem_rd,
  output logic                    out_mem_wr,
  output logic [1:0]              out_br_type,
  output logic [WORD_LEN-1:0]     out_pc,
  output logic                    out_illegal
);

  dec_t                    dec;
  logic [REG_ADDR_LEN-1:0] f_dest;
  logic [REG_ADDR_LEN-1:0] f_src1;
  logic [REG_ADDR_LEN-1:0] f_src2;
  logic [WORD_LEN-1:0]     imm_ext;
  logic                    hit1;
  logic                    hit2;
  logic                    load_hazard;
  logic                    transfer;

  id_ex_issue_decoder u_decoder (
    .opcode (in_instr[31:26]),
    .dec    (dec)
  );

  assign f_dest  = in_instr[25:21];
  assign f_src1  = in_instr[20:16];
  assign f_src2  = in_instr[15:11];
  assign imm_ext = {{(WORD_LEN-16){in_instr[15]}}, in_instr[15:0]};

  // Stores and branches read the register named in the dest field.
  assign rf_addr1 = f_src1;
  assign rf_addr2 = dec.addr2_dest ? f_dest : f_src2;

  // A load still sitting in ID/EX cannot forward its data yet; an
  // instruction reading its destination must wait one cycle.
  assign hit1        = dec.use_src1 && (rf_addr1 == out_dest);
  assign hit2        = dec.use_src2 && (rf_addr2 == out_dest);
  assign load_hazard = out_valid && out_mem_rd && (out_dest != '0) && (hit1 || hit2);

  assign in_ready = !rst && (!out_valid || out_ready) && !load_hazard && !flush;
  assign transfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_exe_cmd <= EXE_NO_OPERATION;
      out_val1    <= '0;
      out_val2    <= '0;
      out_st_val  <= '0;
      out_dest    <= '0;
      out_wb_en   <= 1'b0;
      out_mem_rd  <= 1'b0;
      out_mem_wr  <= 1'b0;
      out_br_type <= BR_NONE;
      out_pc      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid   <= 1'b1;
      out_exe_cmd <= dec.exe_cmd;
      out_val1    <= rf_data1;
      out_val2    <= dec.imm_sel ? imm_ext : rf_data2;
      out_st_val  <= rf_data2;
      out_dest    <= f_dest;
      out_wb_en   <= dec.wb_en;
      out_mem_rd  <= dec.mem_rd;
      out_mem_wr  <= dec.mem_wr;
      out_br_type <= dec.br_type;
      out_pc      <= in_pc;
      out_illegal <= out_illegal || dec.illegal;
    end else if (out_ready) begin
      // Payload is left in place; only out_valid gates it.
      out_valid <= 1'b0;
    end
  end

endmodule
